// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: load opcodes, FSM states and bus layouts.
package mem_stage_pkg;

    localparam int unsigned MEM_BUS_W = 168;
    localparam int unsigned EX_BUS_W  = 173;
    localparam int unsigned ID_BUS_W  = 39;

    // Load width / extension codes carried in ld_op
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // MEM -> WB payload, MSB first
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic        read_tid;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        excep_en;
        logic        adef;
        logic        syscall;
        logic        ale;
        logic        brk;
        logic        ine;
        logic        intr;
        logic [8:0]  esubcode;
    } mem_wb_t;

    // EX -> MEM payload: memory-side control on top of the WB payload
    typedef struct packed {
        logic        req_issued;
        logic        res_from_mem;
        logic [2:0]  ld_op;
        mem_wb_t     wb;
    } ex_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_ld_op,
    output logic [31:0] o_wdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Byte lane selected by the low address bits
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Extension by load type; unknown codes return the whole word
    always_comb begin
        o_wdata_c = i_rdata;
        case (i_ld_op)
            LD_W:    o_wdata_c = i_rdata;
            LD_B:    o_wdata_c = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_wdata_c = {24'd0, w_byte};
            LD_H:    o_wdata_c = {{16{w_half[15]}}, w_half};
            LD_HU:   o_wdata_c = {16'd0, w_half};
            default: o_wdata_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX result, waits for the data-SRAM response,
// aligns load data, and drains responses that belong to flushed loads.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ex_to_mem_valid,
    input  logic [EX_BUS_W-1:0]  ex_to_mem_bus,
    output logic                 mem_allowin,
    input  logic                 wb_allowin,
    output logic                 mem_to_wb_valid,
    output logic [MEM_BUS_W-1:0] mem_to_wb_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic [ID_BUS_W-1:0]  mem_to_id_bus,
    output logic [1:0]           mem_to_ex_bus,
    input  logic                 wb_ex,
    input  logic                 ertn_flush
);

    ex_mem_t    r_bus;
    logic       r_mem_valid;
    mem_state_e r_state;
    mem_state_e w_state_nxt;
    logic [31:0] r_rbuf;
    logic       r_rbuf_valid;
    logic [1:0] r_disc_cnt;

    ex_mem_t    w_ex_in;
    mem_wb_t    w_wb_out;
    logic       w_flush;
    logic       w_allowin;
    logic       w_capture;
    logic       w_resp_cur;
    logic       w_ready_go;
    logic       w_ld_pending;
    logic       w_rbuf_set;
    logic       w_disc_inc;
    logic       w_disc_dec;
    logic [31:0] w_load_src;
    logic [31:0] w_aligned;

    assign w_ex_in    = ex_to_mem_bus;
    assign w_flush    = wb_ex | ertn_flush;
    assign w_resp_cur = data_sram_data_ok & (r_disc_cnt == 2'd0);
    assign w_allowin  = ~r_mem_valid | (w_ready_go & wb_allowin);
    assign w_capture  = ex_to_mem_valid & w_allowin;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: flush beats capture, capture beats the response
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_capture) begin
            w_state_nxt = (w_ex_in.req_issued && !w_ex_in.wb.excep_en) ? ST_WAIT : ST_DONE;
        end else if (w_allowin) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state == ST_WAIT) && w_resp_cur) begin
            w_state_nxt = ST_DONE;
        end
    end

    // FSM outputs: ready when done, or when the current response is arriving
    always_comb begin
        w_ready_go = 1'b0;
        case (r_state)
            ST_DONE: w_ready_go = 1'b1;
            ST_WAIT: w_ready_go = w_resp_cur;
            default: w_ready_go = 1'b0;
        endcase
    end

    // Valid bit: flush clears it, otherwise it follows EX whenever MEM can accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (w_flush) begin
            r_mem_valid <= 1'b0;
        end else if (w_allowin) begin
            r_mem_valid <= ex_to_mem_valid;
        end
    end

    // Payload capture from EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus <= '0;
        end else if (w_capture) begin
            r_bus <= w_ex_in;
        end
    end

    assign w_rbuf_set = r_mem_valid & (r_state == ST_WAIT) & w_resp_cur & ~wb_allowin & ~w_flush;

    // Response buffer: keeps load data while WB stalls, so no re-request is needed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbuf       <= 32'd0;
            r_rbuf_valid <= 1'b0;
        end else if (w_rbuf_set) begin
            r_rbuf       <= data_sram_rdata;
            r_rbuf_valid <= 1'b1;
        end else if (w_flush || w_allowin) begin
            r_rbuf_valid <= 1'b0;
        end
    end

    // A flushed waiting load leaves one orphan response behind, unless it arrives right now
    assign w_disc_inc = w_flush & r_mem_valid & (r_state == ST_WAIT) & ~w_resp_cur;
    assign w_disc_dec = data_sram_data_ok & (r_disc_cnt != 2'd0);

    // Count of orphan responses still to be drained (saturating)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_disc_cnt <= 2'd0;
        end else if (w_disc_inc && !w_disc_dec) begin
            if (r_disc_cnt != 2'd3) begin
                r_disc_cnt <= r_disc_cnt + 2'd1;
            end
        end else if (w_disc_dec && !w_disc_inc) begin
            r_disc_cnt <= r_disc_cnt - 2'd1;
        end
    end

    assign w_load_src = r_rbuf_valid ? r_rbuf : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .i_rdata   (w_load_src),
        .i_offset  (r_bus.wb.rf_wdata[1:0]),
        .i_ld_op   (r_bus.ld_op),
        .o_wdata_c (w_aligned)
    );

    // WB payload: load result replaces rf_wdata, everything else passes through
    always_comb begin
        w_wb_out = r_bus.wb;
        if (r_bus.res_from_mem) begin
            w_wb_out.rf_wdata = w_aligned;
        end
    end

    assign w_ld_pending    = r_mem_valid & r_bus.res_from_mem & ~w_ready_go;

    assign mem_allowin     = w_allowin;
    assign mem_to_wb_valid = r_mem_valid & w_ready_go & ~w_flush;
    assign mem_to_wb_bus   = w_wb_out;
    assign mem_to_id_bus   = {w_ld_pending,
                              r_bus.wb.rf_we & r_mem_valid & ~r_bus.wb.excep_en,
                              r_bus.wb.rf_waddr,
                              w_wb_out.rf_wdata};
    assign mem_to_ex_bus   = {r_bus.wb.excep_en & r_mem_valid, r_bus.wb.ertn & r_mem_valid};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, WB stall buffering, flush drain,
// exception bypass, back-to-back capture and asynchronous reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ex_to_mem_valid;
    logic [172:0] ex_to_mem_bus;
    logic         mem_allowin;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [167:0] mem_to_wb_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [38:0]  mem_to_id_bus;
    logic [1:0]   mem_to_ex_bus;
    logic         wb_ex;
    logic         ertn_flush;

    int n_cmp = 0;
    int n_bad = 0;

    logic [172:0] b1, b2, b3, b4, b5, b6, b7;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .mem_allowin       (mem_allowin),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_to_id_bus     (mem_to_id_bus),
        .mem_to_ex_bus     (mem_to_ex_bus),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush)
    );

    task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // EX payload: {req,res,ld_op, rf_we,waddr,wdata, pc, tid,csr_re,csr_we,csr_num,wmask,wvalue,
    //              ertn,excep_en,adef,syscall,ale,brk,ine,int, esubcode}
    function automatic logic [172:0] mk(input logic req, input logic res, input logic [2:0] op,
                                        input logic [4:0] waddr, input logic [31:0] wdata,
                                        input logic exc, input logic ale);
        logic [172:0] b;
        b = {req, res, op, 1'b1, waddr, wdata, 32'h1C00_0040, 1'b0, 1'b0, 1'b0, 14'h0,
             32'h0, 32'hCAFE_F00D, 1'b0, exc, 1'b0, 1'b0, ale, 1'b0, 1'b0, 1'b0, 9'h0};
        return b;
    endfunction

    function automatic logic [167:0] wbx(input logic [172:0] b, input logic [31:0] wd);
        logic [167:0] e;
        e = b[167:0];
        e[161:130] = wd;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [172:0] b);
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = b;
        step();
        ex_to_mem_valid = 1'b0;
    endtask

    initial begin
        resetn            = 1'b0;
        ex_to_mem_valid   = 1'b0;
        ex_to_mem_bus     = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        wb_ex             = 1'b0;
        ertn_flush        = 1'b0;

        b1 = mk(1'b1, 1'b1, 3'b001, 5'd4, 32'h0000_1003, 1'b0, 1'b0);
        b2 = mk(1'b1, 1'b1, 3'b100, 5'd5, 32'h0000_2002, 1'b0, 1'b0);
        b3 = mk(1'b1, 1'b1, 3'b010, 5'd5, 32'h0000_2002, 1'b0, 1'b0);
        b4 = mk(1'b1, 1'b1, 3'b000, 5'd6, 32'h0000_3000, 1'b0, 1'b0);
        b5 = mk(1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_4000, 1'b0, 1'b0);
        b6 = mk(1'b1, 1'b0, 3'b000, 5'd8, 32'hABCD_0123, 1'b1, 1'b1);
        b7 = mk(1'b0, 1'b0, 3'b000, 5'd9, 32'h1234_5678, 1'b0, 1'b0);

        // Reset state
        step();
        step();
        chk("rst_allowin", 168'(mem_allowin), 168'(1'b1));
        chk("rst_wbvalid", 168'(mem_to_wb_valid), 168'(1'b0));
        chk("rst_wbbus",   mem_to_wb_bus, 168'd0);
        chk("rst_idbus",   168'(mem_to_id_bus), 168'd0);
        chk("rst_exbus",   168'(mem_to_ex_bus), 168'd0);
        resetn = 1'b1;
        step();

        // 1: ld.b offset 3, response two cycles after capture
        issue(b1);
        settle();
        chk("t1_pend_c1",  168'(mem_to_id_bus[38]), 168'(1'b1));
        chk("t1_valid_c1", 168'(mem_to_wb_valid), 168'(1'b0));
        chk("t1_allow_c1", 168'(mem_allowin), 168'(1'b0));
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        settle();
        chk("t1_valid",  168'(mem_to_wb_valid), 168'(1'b1));
        chk("t1_wbbus",  mem_to_wb_bus, wbx(b1, 32'hFFFF_FF80));
        chk("t1_idbus",  168'(mem_to_id_bus), 168'({1'b0, 1'b1, 5'd4, 32'hFFFF_FF80}));
        chk("t1_allow",  168'(mem_allowin), 168'(1'b1));
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk("t1_valid_after", 168'(mem_to_wb_valid), 168'(1'b0));

        // 2: ld.hu / ld.h upper half
        issue(b2);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        settle();
        chk("t2_hu_valid", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t2_hu_data",  168'(mem_to_wb_bus[161:130]), 168'(32'h0000_8001));
        step();
        data_sram_data_ok = 1'b0;
        issue(b3);
        data_sram_data_ok = 1'b1;
        settle();
        chk("t2_h_data",   168'(mem_to_wb_bus[161:130]), 168'(32'hFFFF_8001));
        chk("t2_h_idbus",  168'(mem_to_id_bus[31:0]), 168'(32'hFFFF_8001));
        step();
        data_sram_data_ok = 1'b0;

        // 3: WB stalls three cycles while the response arrives
        issue(b4);
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        settle();
        chk("t3_valid_a", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t3_allow_a", 168'(mem_allowin), 168'(1'b0));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        settle();
        chk("t3_data_b",  168'(mem_to_wb_bus[161:130]), 168'(32'hDEAD_BEEF));
        chk("t3_pend_b",  168'(mem_to_id_bus[38]), 168'(1'b0));
        chk("t3_allow_b", 168'(mem_allowin), 168'(1'b0));
        step();
        step();
        wb_allowin = 1'b1;
        settle();
        chk("t3_valid_d", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t3_data_d",  168'(mem_to_wb_bus[161:130]), 168'(32'hDEAD_BEEF));
        chk("t3_allow_d", 168'(mem_allowin), 168'(1'b1));
        step();
        settle();
        chk("t3_valid_e", 168'(mem_to_wb_valid), 168'(1'b0));

        // 4: flush while waiting, orphan response must be dropped
        issue(b5);
        wb_ex = 1'b1;
        settle();
        chk("t4_valid_fl", 168'(mem_to_wb_valid), 168'(1'b0));
        step();
        wb_ex = 1'b0;
        settle();
        chk("t4_allow",  168'(mem_allowin), 168'(1'b1));
        chk("t4_disc1",  168'(dut.r_disc_cnt), 168'(2'd1));
        issue(b5);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        settle();
        chk("t4_drop_valid", 168'(mem_to_wb_valid), 168'(1'b0));
        chk("t4_drop_pend",  168'(mem_to_id_bus[38]), 168'(1'b1));
        step();
        data_sram_rdata = 32'h2222_2222;
        settle();
        chk("t4_take_valid", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t4_take_data",  168'(mem_to_wb_bus[161:130]), 168'(32'h2222_2222));
        chk("t4_disc0",      168'(dut.r_disc_cnt), 168'(2'd0));
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk("t4_valid_after", 168'(mem_to_wb_valid), 168'(1'b0));

        // 4b: response in the same cycle as the flush is consumed
        issue(b5);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        wb_ex             = 1'b1;
        settle();
        chk("t4b_valid", 168'(mem_to_wb_valid), 168'(1'b0));
        step();
        data_sram_data_ok = 1'b0;
        wb_ex             = 1'b0;
        settle();
        chk("t4b_disc", 168'(dut.r_disc_cnt), 168'(2'd0));
        issue(b5);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_3333;
        settle();
        chk("t4b_next_valid", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t4b_next_data",  168'(mem_to_wb_bus[161:130]), 168'(32'h3333_3333));
        step();
        data_sram_data_ok = 1'b0;

        // 5: exception capture skips the wait; next instruction follows with no bubble
        issue(b6);
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = b7;
        settle();
        chk("t5_valid",  168'(mem_to_wb_valid), 168'(1'b1));
        chk("t5_exbus",  168'(mem_to_ex_bus), 168'(2'b10));
        chk("t5_id_we",  168'(mem_to_id_bus[37]), 168'(1'b0));
        chk("t5_wbbus",  mem_to_wb_bus, b6[167:0]);
        chk("t5_allow",  168'(mem_allowin), 168'(1'b1));
        step();
        ex_to_mem_valid = 1'b0;
        settle();
        chk("t5_b2b_valid", 168'(mem_to_wb_valid), 168'(1'b1));
        chk("t5_b2b_wbbus", mem_to_wb_bus, b7[167:0]);
        chk("t5_b2b_idbus", 168'(mem_to_id_bus), 168'({1'b0, 1'b1, 5'd9, 32'h1234_5678}));
        chk("t5_b2b_exbus", 168'(mem_to_ex_bus), 168'(2'b00));
        step();
        settle();
        chk("t5_valid_after", 168'(mem_to_wb_valid), 168'(1'b0));

        // 6: asynchronous reset in the middle of a wait
        issue(b5);
        settle();
        chk("t6_pend", 168'(mem_to_id_bus[38]), 168'(1'b1));
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_valid", 168'(mem_to_wb_valid), 168'(1'b0));
        chk("t6_wbbus", mem_to_wb_bus, 168'd0);
        chk("t6_idbus", 168'(mem_to_id_bus), 168'd0);
        chk("t6_exbus", 168'(mem_to_ex_bus), 168'd0);
        chk("t6_allow_rst", 168'(mem_allowin), 168'(1'b1));
        step();
        resetn = 1'b1;
        step();
        chk("t6_allow_rel", 168'(mem_allowin), 168'(1'b1));
        chk("t6_valid_rel", 168'(mem_to_wb_valid), 168'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
